// File: rtl/irq_controller.sv
// irq_controller
//   Interrupt controller that feeds the CPU's 16-bit interrupt vector. Each of the
//   NUM_IRQ raw sources is synchronised, then captured into a pending bit as either a
//   rising edge or a level. Pending, enable and edge-mode state live in an 8-word
//   memory-mapped window that uses the CPU data-port address/byte-enable format.
//
//   Ports
//     clk      in   system clock
//     rst      in   asynchronous active-high reset
//     irq_src  in   [NUM_IRQ] raw asynchronous interrupt sources
//     wen      in   [4]  byte write enables, wen[i] -> wdata[8i+7:8i]
//     waddr    in   [ADDR_W] write word address
//     wdata    in   [32] write data
//     raddr    in   [ADDR_W] read word address
//     rdata    out  [32] registered read data (raddr of previous cycle)
//     rhit     out  registered: previous raddr fell inside the window
//     irq_out  out  [16] pending & enable, zero-extended
//     irq_any  out  OR of irq_out
//
//   Word offsets: 0 PENDING (R, W1C), 1 ENABLE, 2 EDGE (1 = rising edge),
//   3 FORCE (W1S, reads 0), 4 ACTIVE, 5 HIGHEST, 6-7 reserved.
module irq_controller #(
  parameter int                NUM_IRQ     = 16,
  parameter int                ADDR_W      = 18,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 18'h3FF00,
  parameter int                SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic [3:0]         wen,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [31:0]        wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [31:0]        rdata,
  output logic               rhit,
  output logic [15:0]        irq_out,
  output logic               irq_any
);

  localparam logic [2:0] OFF_PENDING = 3'd0;
  localparam logic [2:0] OFF_ENABLE  = 3'd1;
  localparam logic [2:0] OFF_EDGE    = 3'd2;
  localparam logic [2:0] OFF_FORCE   = 3'd3;
  localparam logic [2:0] OFF_ACTIVE  = 3'd4;
  localparam logic [2:0] OFF_HIGHEST = 3'd5;

  function automatic logic [31:0] zext(input logic [NUM_IRQ-1:0] v);
    zext = '0;
    zext[NUM_IRQ-1:0] = v;
  endfunction

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] edge_q, edge_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rhit_q, rhit_d;

  logic [NUM_IRQ-1:0] s;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] wbits, clr, frc, set;
  logic [31:0]        bmask, wbits_full;
  logic [ADDR_W-1:0]  wr_off, rd_off;
  logic               wr_hit, rd_hit;
  logic [4:0]         hi_idx;
  logic               unused_wbits;

  assign s      = sync_q[SYNC_STAGES-1];
  assign active = pending_q & enable_q;

  // Window decode by subtraction: addresses below BASE_ADDR wrap to a large
  // offset, so a single upper-bits-zero test covers both ends of the window.
  assign wr_off = waddr - BASE_ADDR;
  assign rd_off = raddr - BASE_ADDR;
  assign wr_hit = (wr_off[ADDR_W-1:3] == '0);
  assign rd_hit = (rd_off[ADDR_W-1:3] == '0);

  assign bmask        = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
  assign wbits_full   = wdata & bmask;
  assign wbits        = wbits_full[NUM_IRQ-1:0];
  assign unused_wbits = ^wbits_full[31:NUM_IRQ];

  // Write decode and pending update. Set is ORed in last so it wins over a
  // same-cycle write-1-to-clear.
  always_comb begin
    clr      = '0;
    frc      = '0;
    enable_d = enable_q;
    edge_d   = edge_q;
    if (wr_hit) begin
      case (wr_off[2:0])
        OFF_PENDING: clr      = wbits;
        OFF_ENABLE:  enable_d = (enable_q & ~bmask[NUM_IRQ-1:0]) | wbits;
        OFF_EDGE:    edge_d   = (edge_q & ~bmask[NUM_IRQ-1:0]) | wbits;
        OFF_FORCE:   frc      = wbits;
        default:     ;
      endcase
    end
    set       = (edge_q & s & ~prev_q) | (~edge_q & s) | frc;
    pending_d = (pending_q & ~clr) | set;
  end

  // Lowest-numbered active source; descending scan so the lowest index is written last.
  always_comb begin
    hi_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) hi_idx = 5'(i);
    end
  end

  always_comb begin
    rdata_d = '0;
    rhit_d  = rd_hit;
    if (rd_hit) begin
      case (rd_off[2:0])
        OFF_PENDING: rdata_d = zext(pending_q);
        OFF_ENABLE:  rdata_d = zext(enable_q);
        OFF_EDGE:    rdata_d = zext(edge_q);
        OFF_ACTIVE:  rdata_d = zext(active);
        OFF_HIGHEST: rdata_d = {|active, 26'b0, hi_idx};
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      edge_q    <= '0;
      rdata_q   <= '0;
      rhit_q    <= 1'b0;
    end else begin
      sync_q[0] <= irq_src;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q    <= s;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      edge_q    <= edge_d;
      rdata_q   <= rdata_d;
      rhit_q    <= rhit_d;
    end
  end

  assign rdata = rdata_q;
  assign rhit  = rhit_q;

  always_comb begin
    irq_out = '0;
    irq_out[NUM_IRQ-1:0] = active;
  end

  assign irq_any = |irq_out;

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

  localparam logic [17:0] B = 18'h3FF00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] irq_src = '0;
  logic [3:0]  wen = '0;
  logic [17:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic [17:0] raddr = '0;
  logic [31:0] rdata;
  logic        rhit;
  logic [15:0] irq_out;
  logic        irq_any;

  int vectors = 0;
  int miscompares = 0;

  irq_controller #(
    .NUM_IRQ(16), .ADDR_W(18), .BASE_ADDR(18'h3FF00), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .wen(wen), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rdata), .rhit(rhit),
    .irq_out(irq_out), .irq_any(irq_any)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [17:0] a, input logic [31:0] d, input logic [3:0] be);
    waddr = a;
    wdata = d;
    wen   = be;
    tick(1);
    wen   = '0;
  endtask

  task automatic rd(input logic [17:0] a, output logic [31:0] d, output logic h);
    raddr = a;
    tick(1);
    d = rdata;
    h = rhit;
  endtask

  task automatic test_reset;
    tick(2);
    vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h want %h", rdata, 32'h0); end
    vectors++; if (rhit !== 1'b0) begin miscompares++; $display("FAIL reset_rhit got %b want 0", rhit); end
    vectors++; if (irq_out !== 16'h0) begin miscompares++; $display("FAIL reset_irq_out got %h want 0000", irq_out); end
    vectors++; if (irq_any !== 1'b0) begin miscompares++; $display("FAIL reset_irq_any got %b want 0", irq_any); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_edge_capture;
    wr(B + 1, 32'h1, 4'hF);
    wr(B + 2, 32'h1, 4'hF);
    irq_src[0] = 1'b1;
    tick(2);
    vectors++; if (irq_out !== 16'h0) begin miscompares++; $display("FAIL edge_early got %h want 0000", irq_out); end
    tick(1);
    vectors++; if (irq_out !== 16'h0001) begin miscompares++; $display("FAIL edge_latency got %h want 0001", irq_out); end
    vectors++; if (irq_any !== 1'b1) begin miscompares++; $display("FAIL edge_any got %b want 1", irq_any); end
  endtask

  task automatic test_edge_clear;
    wr(B + 0, 32'h1, 4'hF);
    vectors++; if (irq_out !== 16'h0) begin miscompares++; $display("FAIL edge_w1c got %h want 0000", irq_out); end
    tick(3);
    vectors++; if (irq_out !== 16'h0) begin miscompares++; $display("FAIL edge_no_retrigger got %h want 0000", irq_out); end
    irq_src[0] = 1'b0;
    tick(3);
    irq_src[0] = 1'b1;
    tick(3);
    vectors++; if (irq_out !== 16'h0001) begin miscompares++; $display("FAIL edge_new_rise got %h want 0001", irq_out); end
    irq_src[0] = 1'b0;
    tick(3);
    wr(B + 0, 32'h1, 4'hF);
  endtask

  task automatic test_level;
    wr(B + 1, 32'h8, 4'hF);
    wr(B + 2, 32'h0, 4'hF);
    irq_src[3] = 1'b1;
    tick(3);
    vectors++; if (irq_out !== 16'h0008) begin miscompares++; $display("FAIL level_set got %h want 0008", irq_out); end
    wr(B + 0, 32'h8, 4'hF);
    vectors++; if (irq_out !== 16'h0008) begin miscompares++; $display("FAIL level_resets got %h want 0008", irq_out); end
    irq_src[3] = 1'b0;
    tick(3);
    wr(B + 0, 32'h8, 4'hF);
    vectors++; if (irq_out !== 16'h0) begin miscompares++; $display("FAIL level_clear got %h want 0000", irq_out); end
  endtask

  task automatic test_force_read;
    logic [31:0] d;
    logic        h;
    wr(B + 1, 32'h20, 4'hF);
    wr(B + 3, 32'h30, 4'hF);
    vectors++; if (irq_out !== 16'h0020) begin miscompares++; $display("FAIL force_irq_out got %h want 0020", irq_out); end
    rd(B + 0, d, h);
    vectors++; if (d !== 32'h30) begin miscompares++; $display("FAIL force_pending got %h want 00000030", d); end
    vectors++; if (h !== 1'b1) begin miscompares++; $display("FAIL force_rhit got %b want 1", h); end
    rd(B + 4, d, h);
    vectors++; if (d !== 32'h20) begin miscompares++; $display("FAIL active got %h want 00000020", d); end
    rd(B + 5, d, h);
    vectors++; if (d !== 32'h80000005) begin miscompares++; $display("FAIL highest got %h want 80000005", d); end
    rd(B + 3, d, h);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL force_reads0 got %h want 0", d); end
    rd(B + 6, d, h);
    vectors++; if (d !== 32'h0 || h !== 1'b1) begin miscompares++; $display("FAIL reserved got %h/%b want 0/1", d, h); end
    wr(B + 1, 32'h0, 4'hF);
    rd(B + 5, d, h);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL highest_none got %h want 0", d); end
    wr(B + 0, 32'hFFFF, 4'hF);
  endtask

  task automatic test_set_wins;
    logic [31:0] d;
    logic        h;
    wr(B + 2, 32'h4, 4'hF);
    wr(B + 3, 32'h4, 4'hF);
    irq_src[2] = 1'b1;
    tick(2);
    wr(B + 0, 32'h4, 4'hF);
    rd(B + 0, d, h);
    vectors++; if (d !== 32'h4) begin miscompares++; $display("FAIL set_wins got %h want 00000004", d); end
    wr(B + 0, 32'h4, 4'hF);
    rd(B + 0, d, h);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL later_clear got %h want 0", d); end
    irq_src[2] = 1'b0;
    wr(B + 2, 32'h0, 4'hF);
  endtask

  task automatic test_byte_lanes;
    logic [31:0] d;
    logic        h;
    wr(B + 1, 32'h0, 4'hF);
    raddr = B + 1;
    waddr = B + 1;
    wdata = 32'hFFFF;
    wen   = 4'b0010;
    tick(1);
    wen   = '0;
    vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL read_before_write got %h want 0", rdata); end
    rd(B + 1, d, h);
    vectors++; if (d !== 32'hFF00) begin miscompares++; $display("FAIL byte_lane got %h want 0000ff00", d); end
    wr(B + 1, 32'hFFFFFFFF, 4'hF);
    rd(B + 1, d, h);
    vectors++; if (d !== 32'hFFFF) begin miscompares++; $display("FAIL upper_ignored got %h want 0000ffff", d); end
  endtask

  task automatic test_window;
    logic [31:0] d;
    logic        h;
    wr(B + 9, 32'h0, 4'hF);
    wr(B - 1, 32'h0, 4'hF);
    rd(B + 1, d, h);
    vectors++; if (d !== 32'hFFFF) begin miscompares++; $display("FAIL out_write_ignored got %h want 0000ffff", d); end
    rd(B + 8, d, h);
    vectors++; if (d !== 32'h0 || h !== 1'b0) begin miscompares++; $display("FAIL above_window got %h/%b want 0/0", d, h); end
    rd(B - 1, d, h);
    vectors++; if (d !== 32'h0 || h !== 1'b0) begin miscompares++; $display("FAIL below_window got %h/%b want 0/0", d, h); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic        h;
    wr(B + 3, 32'hFFFF, 4'hF);
    vectors++; if (irq_out !== 16'hFFFF) begin miscompares++; $display("FAIL all_pending got %h want ffff", irq_out); end
    irq_src[1] = 1'b1;
    raddr = B + 1;
    tick(1);
    rst = 1'b1;
    #1;
    vectors++; if (irq_out !== 16'h0 || irq_any !== 1'b0) begin miscompares++; $display("FAIL async_reset_irq got %h/%b want 0000/0", irq_out, irq_any); end
    vectors++; if (rdata !== 32'h0 || rhit !== 1'b0) begin miscompares++; $display("FAIL async_reset_read got %h/%b want 0/0", rdata, rhit); end
    tick(1);
    rst = 1'b0;
    rd(B + 0, d, h);
    vectors++; if (d !== 32'h0 && d !== 32'h2) begin miscompares++; $display("FAIL pending_lost got %h want 0 or 2", d); end
    wr(B + 1, 32'h2, 4'hF);
    tick(3);
    vectors++; if (irq_out !== 16'h0002) begin miscompares++; $display("FAIL recapture got %h want 0002", irq_out); end
    irq_src[1] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge_capture();
    test_edge_clear();
    test_level();
    test_force_read();
    test_set_wins();
    test_byte_lanes();
    test_window();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
